// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid-buffered pipeline stage with valid/ready on both
// sides and a synchronous flush. Every output comes straight from a flop, so
// no combinational path links out_ready to in_ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | nothing held; out_valid=0, in_ready=1, occ=0
//   BUSY  | one beat in main; out_valid=1, in_ready=1, occ=1
//   FULL  | main stalled, second beat in skid; out_valid=1, in_ready=0, occ=2
module pipe_skid #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    input  logic         flush,
    output logic [1:0]   occ
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    // Next-state and register load enables; flush overrides everything.
    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        load_main_in = 1'b1;
                        state_nx     = BUSY;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        load_main_in = 1'b1;
                    end else if (in_valid) begin
                        load_skid = 1'b1;
                        state_nx  = FULL;
                    end else if (out_ready) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    // in_valid is ignored here because in_ready is low.
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_nx       = BUSY;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Payload registers; flush leaves their contents alone, only validity is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occ       = state;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid.sv
// Directed bench for pipe_skid, followed by a seeded random flow-control run
// checked against a queue reference.
module tb_pipe_skid;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         flush = 1'b0;
    logic [1:0]   occ;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_skid #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] e_occ,
                             input logic e_ov, input logic e_ir);
        chk({tag, "_occ"}, 64'(occ), 64'(e_occ));
        chk({tag, "_ovalid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, "_iready"}, 64'(in_ready), 64'(e_ir));
    endtask

    logic [N-1:0] q[$];
    logic [N-1:0] seq_cnt;
    logic         up;
    logic         dn;

    initial begin
        // Reset values while reset is held.
        #3;
        chk_state("rst", 2'd0, 1'b0, 1'b1);
        chk("rst_data", out_data, 64'h0);

        // First beat right after reset release.
        #9;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        out_ready = 1'b1;
        tick();
        chk("first_data", out_data, 64'hA);
        chk_state("first", 2'd1, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick();
        chk_state("first_drain", 2'd0, 1'b0, 1'b1);

        // Full-throughput stream.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            chk("stream_data", out_data, 64'(i));
            chk_state("stream", 2'd1, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk_state("stream_end", 2'd0, 1'b0, 1'b1);

        // Stall: 1 in main, 2 in skid, 3 held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        tick();
        chk_state("stall1", 2'd1, 1'b1, 1'b1);
        in_data = 64'h2;
        tick();
        chk_state("stall2", 2'd2, 1'b1, 1'b0);
        chk("stall2_data", out_data, 64'h1);
        in_data = 64'h3;
        tick();
        chk_state("stall_hold", 2'd2, 1'b1, 1'b0);
        chk("stall_hold_data", out_data, 64'h1);
        // Release: 0x1 leaves at this edge, 0x3 is still refused (in_ready=0).
        out_ready = 1'b1;
        tick();
        chk("drain_2", out_data, 64'h2);
        chk_state("drain_2", 2'd1, 1'b1, 1'b1);
        tick();
        chk("drain_3", out_data, 64'h3);
        chk_state("drain_3", 2'd1, 1'b1, 1'b1);
        in_data = 64'h4;
        tick();
        chk("drain_4", out_data, 64'h4);
        in_valid = 1'b0;
        tick();
        chk_state("drain_end", 2'd0, 1'b0, 1'b1);

        // Flush from FULL with a simultaneous offered beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        tick();
        in_data = 64'h12;
        tick();
        chk_state("pre_flush", 2'd2, 1'b1, 1'b0);
        flush   = 1'b1;
        in_data = 64'hF;
        tick();
        chk_state("flush", 2'd0, 1'b0, 1'b1);
        chk("flush_keeps_main", out_data, 64'h11);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_state("post_flush", 2'd0, 1'b0, 1'b1);

        // Asynchronous reset while BUSY holding 0x5.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        tick();
        chk_state("busy5", 2'd1, 1'b1, 1'b1);
        chk("busy5_data", out_data, 64'h5);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 2'd0, 1'b0, 1'b1);
        chk("async_rst_data", out_data, 64'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_state("after_rst", 2'd0, 1'b0, 1'b1);
        chk("after_rst_data", out_data, 64'h0);

        // Random flow control against a queue reference.
        seq_cnt = 64'hC0DE_0000_0000_0000;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = seq_cnt;
            up = in_valid && (q.size() != 2);
            dn = out_ready && (q.size() != 0);
            tick();
            if (dn) void'(q.pop_front());
            if (up) begin
                q.push_back(in_data);
                seq_cnt = seq_cnt + 64'd1;
            end
            chk("rnd_occ", 64'(occ), 64'(q.size()));
            chk("rnd_ovalid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd_iready", 64'(in_ready), 64'(q.size() != 2));
            if (q.size() != 0) chk("rnd_data", out_data, q[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
